gauss3x3_stream_filter: RTL and testbench
=========================================

Name: gauss3x3_stream_filter

Overview:
- Streaming 3x3 Gaussian blur stage that sits directly downstream of the camera pixel source.
- Consumes the camera's raster-order 8-bit pixel stream (data_valid/data_in), buffers two image rows and forms 3x3 windows.
- Emits one filtered pixel per fully interior window with kernel 1-2-1/2-4-2/1-2-1, normalised by >>4.
- Feeds later filter/sink stages via filt_valid/filt_out.

Parameters:
- IMG_W, 4, pixels per row (>=3)
- IMG_H, 3, rows per frame (>=3)
- DATA_W, 8, pixel width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- data_valid  in  1  pixel qualifier from the camera
- data_in  in  DATA_W  pixel, raster order; ignored (may be Z/X) when data_valid=0
- filt_valid  out  1  filt_out holds a filtered pixel this cycle
- filt_out  out  DATA_W  filtered pixel
- frame_done  out  1  one-cycle pulse coincident with the last filtered pixel of a complete frame

Behaviour:
- Reset: filt_valid=0, filt_out=0, frame_done=0, col=0, row=0, pipeline valids cleared. Line-buffer RAM is not cleared; its contents are don't-care.
- Acceptance: a pixel is accepted on each rising edge with data_valid=1. There is no backpressure. Pixels arrive back-to-back.
- Position counters:
  - col counts 0..IMG_W-1; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. The next accepted pixel starts a new frame, with no gap required.
- Frame abort: data_valid=0 for any cycle forces col=row=0 on that edge. The partial frame is abandoned: no frame_done, and windows not yet started are not produced. Results already in the pipeline still drain.
- Line buffers: two IMG_W-deep row buffers (row r-1, row r-2), addressed by col. Each is read and written in the same cycle at the same address (read-before-write).
- Window: 3x3 shift register. Each accepted pixel shifts in column {row r-2 buf[col], row r-1 buf[col], data_in}.
- Window generation: a window is complete when the accepted pixel has row>=2 and col>=2. Its centre is (row-1, col-1). Windows never straddle rows or frames.
- Pipeline, 2 cycles:
  - S1 registers the weighted sum, DATA_W+4 bits unsigned (max 16*255=4080, no overflow).
  - S2 registers filt_out = sum[DATA_W+3:4] (truncation, no rounding) and raises filt_valid.
  - If the completing pixel is sampled on edge t, filt_valid=1 after edge t+2 for exactly one cycle per window.
- Output rate: up to (IMG_W-2) consecutive outputs per row; filt_valid is low during row turnarounds. Per frame there are (IMG_W-2)*(IMG_H-2) outputs; the default is 2.
- filt_out holds its last value when filt_valid=0.
- frame_done is asserted in the same cycle as the output whose centre is (IMG_H-2, IMG_W-2), only if no abort occurred during that frame.
- Mid-operation reset clears all valids immediately. The first output after reset requires a complete new frame start.

Decomposition:
- Shared package gauss_pkg: IMG_W/IMG_H/DATA_W defaults, SUM_W=DATA_W+4, kernel weight constants, col/row width localparams ($clog2).
- One sub-module, line_buffer: single-port read-before-write RAM of depth IMG_W x DATA_W. It is instantiated twice, or once with 2*DATA_W width.

Test Plan:
- Reset, then frame BC 27 81 FF / CE 1F E0 A9 / 38 2B D4 11 with data_valid held high for 12 cycles:
  - filt_out=8'h6C (sum 1733) 2 cycles after pixel 10 (D4) is sampled.
  - Then 8'h91 (sum 2332) on the next cycle, with frame_done=1.
  - No other filt_valid pulses.
- Two frames back-to-back, 24 valid cycles: the outputs 6C, 91 repeat, and frame_done pulses twice. This shows the second frame is not contaminated by the first.
- All-FF frame: every output is 8'hFF (sum 4080, no overflow). All-00 frame: outputs 8'h00.
- Drop data_valid for 1 cycle after pixel 6:
  - No outputs, no frame_done.
  - Resume with a full 12-pixel frame: outputs 6C, 91 and frame_done once.
- Assert rst mid-frame (after pixel 10, while an output is in flight):
  - filt_valid, frame_done and filt_out go to 0 immediately and the in-flight result is discarded.
  - The following full frame yields 6C, 91.
- IMG_W=5, IMG_H=4 with a ramp frame (pixel = index):
  - Outputs are 6 interior pixels, equal to the centre index (linear ramp, truncated), in raster order.
  - frame_done is asserted with the 6th output.

Source files
------------

// File: rtl/gauss_pkg.sv
// ---------------------------------------------------------------------------
// gauss_pkg
// Shared definitions for the 3x3 Gaussian stream filter:
//   - default image geometry and pixel width
//   - normalisation shift and 1-2-1 / 2-4-2 / 1-2-1 kernel weights
//   - width helpers for the position counters and the weighted sum
//   - pipeline tag carried alongside each window (valid + last-of-frame)
// ---------------------------------------------------------------------------
package gauss_pkg;

   localparam int IMG_W_DEF  = 4;
   localparam int IMG_H_DEF  = 3;
   localparam int DATA_W_DEF = 8;

   // Kernel weights add up to 16, so the normalisation is a plain >>4.
   localparam int NORM_SHIFT = 4;
   localparam int K_CORNER   = 1;
   localparam int K_EDGE     = 2;
   localparam int K_CENTRE   = 4;

   // Counter width for a range 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // The weighted sum needs NORM_SHIFT extra bits above the pixel width
   // (16 * max pixel fits exactly).
   function automatic int sum_width(input int data_w);
      return data_w + NORM_SHIFT;
   endfunction

   // Weight of window tap (r, c), both indices 0..2 with 1 as the centre.
   function automatic int kernel_weight(input int r, input int c);
      if (r == 1 && c == 1) begin
         return K_CENTRE;
      end else if (r == 1 || c == 1) begin
         return K_EDGE;
      end
      return K_CORNER;
   endfunction

   typedef struct packed {
      logic valid;   // this pipeline slot carries a complete window
      logic last;    // window centred on the last interior pixel of the frame
   } pipe_tag_t;

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Single-port read-before-write RAM. The read is combinational so a value
// written on this edge is only seen on a later access; the word read in the
// same cycle as a write is the old contents.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   addr     in   shared read/write address
//   wr_data  in   data written at addr on the rising edge when we=1
//   rd_data  out  current contents at addr
// ---------------------------------------------------------------------------
module line_buffer
   import gauss_pkg::*;
#(
   parameter int DEPTH  = IMG_W_DEF,
   parameter int WIDTH  = 2 * DATA_W_DEF,
   parameter int ADDR_W = cnt_width(IMG_W_DEF)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem_q [0:DEPTH-1];

   assign rd_data = mem_q[addr];

   // Contents are deliberately not reset: every location is rewritten by the
   // first two rows of a frame before any window reads it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/gauss3x3_stream_filter.sv
// ---------------------------------------------------------------------------
// gauss3x3_stream_filter
// Streaming 3x3 Gaussian blur on a raster-order pixel stream. Two previous
// rows are held in a line buffer; each accepted pixel shifts a new column
// into a 3x3 window. Interior windows are summed with the 1-2-1 kernel and
// normalised by >>4 over a two-stage pipeline.
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst         in   asynchronous active-high reset
//   data_valid  in   pixel qualifier; a low cycle abandons the current frame
//   data_in     in   pixel, ignored when data_valid=0
//   filt_valid  out  filt_out carries a filtered pixel this cycle
//   filt_out    out  filtered pixel (holds when filt_valid=0)
//   frame_done  out  pulse with the last filtered pixel of a complete frame
// ---------------------------------------------------------------------------
module gauss3x3_stream_filter
   import gauss_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              filt_valid,
   output logic [DATA_W-1:0] filt_out,
   output logic              frame_done
);

   localparam int COL_W = cnt_width(IMG_W);
   localparam int ROW_W = cnt_width(IMG_H);
   localparam int SUM_W = sum_width(DATA_W);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [2*DATA_W-1:0] lb_rd, lb_wr;
   // win_q[r][c]: r=0 is row r-2, r=2 the incoming row; c=2 is the newest column.
   logic [DATA_W-1:0]   win_q [0:2][0:2];
   logic [DATA_W-1:0]   win_d [0:2][0:2];
   pipe_tag_t           win_tag_q, win_tag_d;
   pipe_tag_t           sum_tag_q, sum_tag_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [DATA_W-1:0]   filt_out_q, filt_out_d;
   logic                filt_valid_q, filt_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                unused_sum_lsbs;

   // Raster position of the pixel presented this cycle. Any idle cycle
   // returns to the top-left corner, abandoning a partial frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (!data_valid) begin
         col_d = '0;
         row_d = '0;
      end else if (col_q == COL_LAST) begin
         col_d = '0;
         row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
         col_d = col_q + COL_W'(1);
      end
   end

   // Both history rows share one RAM word: low half is row r-1, high half
   // row r-2. On each accept the old row r-1 pixel moves up to r-2.
   assign lb_wr = {lb_rd[DATA_W-1:0], data_in};

   line_buffer #(
      .DEPTH  (IMG_W),
      .WIDTH  (2 * DATA_W),
      .ADDR_W (COL_W)
   ) u_line_buf (
      .clk     (clk),
      .we      (data_valid),
      .addr    (col_q),
      .wr_data (lb_wr),
      .rd_data (lb_rd)
   );

   // Window shift and completion tag. A window needs two earlier rows and
   // two earlier columns of the same row; because any gap resets the
   // position, those columns are always contiguous and in this frame.
   always_comb begin
      win_d = win_q;
      if (data_valid) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb_rd[2*DATA_W-1:DATA_W];
         win_d[1][2] = lb_rd[DATA_W-1:0];
         win_d[2][2] = data_in;
      end
      win_tag_d.valid = data_valid && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      win_tag_d.last  = win_tag_d.valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
   end

   // Stage 1: weighted sum of the registered window.
   always_comb begin
      sum_d = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            sum_d = sum_d + SUM_W'(win_q[r][c]) * SUM_W'(kernel_weight(r, c));
         end
      end
      sum_tag_d = win_tag_q;
   end

   // Stage 2: truncating normalisation; the output holds between results.
   always_comb begin
      filt_out_d   = filt_out_q;
      filt_valid_d = sum_tag_q.valid;
      frame_done_d = sum_tag_q.valid && sum_tag_q.last;
      if (sum_tag_q.valid) begin
         filt_out_d = sum_q[SUM_W-1:NORM_SHIFT];
      end
   end

   // Fractional bits are discarded by the truncation.
   assign unused_sum_lsbs = ^sum_q[NORM_SHIFT-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_tag_q    <= '0;
         sum_tag_q    <= '0;
         sum_q        <= '0;
         filt_out_q   <= '0;
         filt_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_tag_q    <= win_tag_d;
         sum_tag_q    <= sum_tag_d;
         sum_q        <= sum_d;
         filt_out_q   <= filt_out_d;
         filt_valid_q <= filt_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Window taps carry no control meaning, so they need no reset.
   always_ff @(posedge clk) begin
      win_q <= win_d;
   end

   assign filt_valid = filt_valid_q;
   assign filt_out   = filt_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gauss3x3_stream_filter.sv
// ---------------------------------------------------------------------------
// tb_gauss3x3_stream_filter
// Drives a 4x3 instance (directed frames + random stream) and a 5x4 instance
// (ramp frame + random stream). A behavioural model stores each frame as an
// image and convolves it directly; a negedge compare process checks every
// cycle of both instances against the model's expected output schedule.
// ---------------------------------------------------------------------------
module tb_gauss3x3_stream_filter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       v0, v1;
   logic [7:0] d0, d1;
   logic       fv0, fv1, fd0, fd1;
   logic [7:0] fo0, fo1;

   gauss3x3_stream_filter #(.IMG_W(4), .IMG_H(3), .DATA_W(8)) dut0 (
      .clk(clk), .rst(rst), .data_valid(v0), .data_in(d0),
      .filt_valid(fv0), .filt_out(fo0), .frame_done(fd0));

   gauss3x3_stream_filter #(.IMG_W(5), .IMG_H(4), .DATA_W(8)) dut1 (
      .clk(clk), .rst(rst), .data_valid(v1), .data_in(d1),
      .filt_valid(fv1), .filt_out(fo1), .frame_done(fd1));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   int  mw [2] = '{4, 5};
   int  mh [2] = '{3, 4};
   int  img [2][8][8];
   int  pidx [2];
   int  tail [2];
   int  head [2];
   int  hold [2];
   int  exp_due  [2][64];
   int  exp_val  [2][64];
   bit  exp_last [2][64];

   typedef struct { int val; bit done; } out_t;
   out_t got0[$];
   out_t got1[$];

   int tf [12] = '{'hBC, 'h27, 'h81, 'hFF, 'hCE, 'h1F, 'hE0, 'hA9, 'h38, 'h2B, 'hD4, 'h11};

   // Gaussian-weighted sum of the 3x3 neighbourhood around (rc, cc).
   function automatic int window_sum(input int i, input int rc, input int cc);
      int s;
      s = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            s += img[i][rc+dr][cc+dc] * (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc));
      return s;
   endfunction

   task automatic model_step(input int i, input logic v, input logic [7:0] d);
      int r, c, k;
      if (v === 1'b1) begin
         r = pidx[i] / mw[i];
         c = pidx[i] % mw[i];
         img[i][r][c] = int'(d);
         if (r >= 2 && c >= 2) begin
            k = tail[i] % 64;
            exp_due[i][k]  = cyc + 3;   // cyc is pre-increment here: due two edges later
            exp_val[i][k]  = window_sum(i, r - 1, c - 1) >> 4;
            exp_last[i][k] = (pidx[i] == mw[i] * mh[i] - 1);
            tail[i]++;
         end
         pidx[i] = (pidx[i] + 1) % (mw[i] * mh[i]);
      end else begin
         pidx[i] = 0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            pidx[i] = 0;
            tail[i] = 0;
         end
      end else begin
         model_step(0, v0, d0);
         model_step(1, v1, d1);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic cmp_step(input int i, input logic fv, input logic [7:0] fo, input logic fd);
      bit   ev;
      int   k;
      out_t o;
      if (rst === 1'b1) begin
         head[i] = 0;
         hold[i] = 0;
         chk($sformatf("d%0d_rst_valid", i), fv, 0);
         chk($sformatf("d%0d_rst_out", i), fo, 0);
         chk($sformatf("d%0d_rst_done", i), fd, 0);
         return;
      end
      k  = head[i] % 64;
      ev = (head[i] != tail[i]) && (exp_due[i][k] <= cyc);
      chk($sformatf("d%0d_valid", i), fv, ev);
      if (fv === 1'b1) begin
         o.val  = int'(fo);
         o.done = fd;
         if (i == 0) got0.push_back(o); else got1.push_back(o);
         $display("d%0d out=%02h done=%0b cycle=%0d", i, fo, fd, cyc);
      end
      if (ev) begin
         chk($sformatf("d%0d_out", i), fo, exp_val[i][k]);
         chk($sformatf("d%0d_done", i), fd, exp_last[i][k]);
         hold[i] = exp_val[i][k];
         head[i]++;
      end else begin
         chk($sformatf("d%0d_hold", i), fo, hold[i]);
         chk($sformatf("d%0d_done_idle", i), fd, 0);
      end
   endtask

   always @(negedge clk) begin
      cmp_step(0, fv0, fo0, fd0);
      cmp_step(1, fv1, fo1, fd1);
   end

   // Literal check of the captured outputs; element 0 in the low byte/bit.
   task automatic expect_got(input int i, input string name, input int n,
                             input logic [63:0] vals, input logic [7:0] dn);
      out_t q[$];
      if (i == 0) q = got0; else q = got1;
      chk({name, "_count"}, q.size(), n);
      for (int k = 0; k < n && k < q.size(); k++) begin
         chk($sformatf("%s_val%0d", name, k), q[k].val, vals[8*k +: 8]);
         chk($sformatf("%s_done%0d", name, k), q[k].done, dn[k]);
      end
      if (i == 0) got0.delete(); else got1.delete();
   endtask

   // ---------------- stimulus ----------------
   task automatic px0(input int p);
      @(negedge clk); v0 = 1'b1; d0 = p[7:0];
   endtask
   task automatic px1(input int p);
      @(negedge clk); v1 = 1'b1; d1 = p[7:0];
   endtask
   task automatic idle0(input int n);
      repeat (n) begin @(negedge clk); v0 = 1'b0; d0 = 'x; end
   endtask
   task automatic idle1(input int n);
      repeat (n) begin @(negedge clk); v1 = 1'b0; d1 = 'x; end
   endtask
   task automatic send_frame0(input int kind);
      for (int k = 0; k < 12; k++) px0(kind == 0 ? tf[k] : (kind == 1 ? 255 : 0));
   endtask

   // Reset asserted between edges so the outputs must clear without a clock.
   task automatic pulse_reset(input int cycles);
      @(negedge clk);
      #2;
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 'x; d1 = 'x;
      #1;
      chk("rst_now_valid0", fv0, 0);
      chk("rst_now_out0", fo0, 0);
      chk("rst_now_done0", fd0, 0);
      chk("rst_now_valid1", fv1, 0);
      chk("rst_now_out1", fo1, 0);
      chk("rst_now_done1", fd1, 0);
      repeat (cycles) @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   function automatic logic [7:0] rand_pix();
      int sel;
      logic [7:0] p;
      sel = $urandom_range(0, 7);
      p = 8'($urandom);
      if (sel == 0) p = 8'h00;
      if (sel == 1) p = 8'hFF;
      return p;
   endfunction

   int r;

   initial begin
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 'x; d1 = 'x;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      // Reference frame with explicit latency checks around pixel 10.
      for (int k = 0; k < 12; k++) px0(tf[k]);
      @(negedge clk);                     // after pixel 11 edge
      chk("lat_early_valid", fv0, 0);
      v0 = 1'b0; d0 = 'x;
      @(negedge clk);                     // two edges after pixel 10
      chk("lat_first_valid", fv0, 1);
      chk("lat_first_out", fo0, 8'h6C);
      chk("lat_first_done", fd0, 0);
      @(negedge clk);
      chk("lat_second_valid", fv0, 1);
      chk("lat_second_out", fo0, 8'h91);
      chk("lat_second_done", fd0, 1);
      idle0(3);
      expect_got(0, "frame_a", 2, 64'h916C, 8'b10);
      chk("model_sum_a0", window_sum(0, 1, 1), 1733);
      chk("model_sum_a1", window_sum(0, 1, 2), 2332);

      // Back-to-back frames.
      send_frame0(0);
      send_frame0(0);
      idle0(5);
      expect_got(0, "frame_bb", 4, 64'h916C916C, 8'b1010);

      // Saturated and zero frames.
      send_frame0(1);
      idle0(5);
      expect_got(0, "frame_ff", 2, 64'hFFFF, 8'b10);
      chk("model_sum_ff", window_sum(0, 1, 1), 4080);
      send_frame0(2);
      idle0(5);
      expect_got(0, "frame_00", 2, 64'h0000, 8'b10);

      // Abort after pixel 6, then a full frame.
      for (int k = 0; k < 7; k++) px0(tf[k]);
      idle0(1);
      send_frame0(0);
      idle0(5);
      expect_got(0, "abort", 2, 64'h916C, 8'b10);

      // Reset while the second result is in flight.
      send_frame0(0);
      idle0(1);
      pulse_reset(1);
      send_frame0(0);
      idle0(5);
      expect_got(0, "midrst", 3, 64'h916C6C, 8'b100);

      // Random stream on the 4x3 instance.
      for (int it = 0; it < 900; it++) begin
         r = $urandom_range(0, 199);
         if (r == 0) pulse_reset(1);
         else if (r < 6) idle0(1 + r % 2);
         else px0(int'(rand_pix()));
      end
      idle0(5);
      got0.delete();

      // Ramp frame on the 5x4 instance: blur of a linear ramp is the centre.
      for (int k = 0; k < 20; k++) px1(k);
      idle1(5);
      expect_got(1, "ramp", 6, 64'h0D0C0B080706, 8'b100000);

      // Random stream on the 5x4 instance.
      for (int it = 0; it < 700; it++) begin
         r = $urandom_range(0, 199);
         if (r == 0) pulse_reset(2);
         else if (r < 4) idle1(1);
         else px1(int'(rand_pix()));
      end
      idle1(5);
      idle0(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
